// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control unit for a five-state multicycle MIPS-style datapath
// (FETCH, DECODE, EXEC, MEM, WB). It decodes the opcode and funct fields
// of the instruction register and drives the datapath steering and strobe
// signals for every cycle. It also counts retired instructions.
//
// Memory handshake: the unit holds ct_mem_req high, together with
// ct_mem_ren or ct_mem_wen, for the whole access. The access completes in
// the first cycle where mem_ready=1 is seen with the request high. No
// request is withdrawn before it completes, except by reset. When
// MEM_HS=0 every access is treated as completing in its first cycle.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   ct_inst       IR[31:26] opcode
//   aluct_inst    IR[5:0] funct
//   alu_zero      ALU zero flag (used by beq/bne in EXEC)
//   mem_ready     memory access complete this cycle
//   ct_pc_wen     PC write
//   ct_pc_src     PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   ct_ir_wen     IR write
//   ct_rf_dst     register-file destination: 1 = rd, 0 = rt
//   ct_rf_wen     register-file write
//   ct_alu_src_a  ALU A operand: 0 = PC, 1 = rs
//   ct_alu_src_b  ALU B operand: 00 rt, 01 const 4, 10 sext imm, 11 imm<<2
//   ct_alu        ALU operation
//   ct_mem_req    memory request
//   ct_mem_ren    memory read
//   ct_mem_wen    memory write
//   ct_data_rf    register-file write data: 1 = memory data, 0 = ALUOut
//   ct_illegal    one-cycle illegal-instruction pulse (in DECODE)
//   ct_state      current FSM state (debug / checker visibility)
//   ct_retired    retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int CNT_W  = 32,
    parameter int MEM_HS = 1,
    parameter int ALU_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       ct_inst,
    input  logic [5:0]       aluct_inst,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             ct_pc_wen,
    output logic [1:0]       ct_pc_src,
    output logic             ct_ir_wen,
    output logic             ct_rf_dst,
    output logic             ct_rf_wen,
    output logic             ct_alu_src_a,
    output logic [1:0]       ct_alu_src_b,
    output logic [ALU_W-1:0] ct_alu,
    output logic             ct_mem_req,
    output logic             ct_mem_ren,
    output logic             ct_mem_wen,
    output logic             ct_data_rf,
    output logic             ct_illegal,
    output logic [2:0]       ct_state,
    output logic [CNT_W-1:0] ct_retired
);

    // Opcodes
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    // ALU operation encodings, zero-extended to ALU_W
    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(4'b0010);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(4'b0110);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(4'b0000);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(4'b0001);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(4'b0111);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           state;
    logic [5:0]       op_q;
    logic [5:0]       fn_q;
    logic [CNT_W-1:0] retired;
    logic             mem_rdy;
    logic             illegal_dec;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDIU: op_legal = 1'b1;
            default:                                            op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic funct_legal(input logic [5:0] fn);
        case (fn)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
            default:                         funct_legal = 1'b0;
        endcase
    endfunction

    // Unknown functs fall back to ADD; they never reach EXEC because
    // DECODE flags them illegal.
    function automatic logic [ALU_W-1:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000, 6'b100001: funct_alu = ALU_ADD;
            6'b100010, 6'b100011: funct_alu = ALU_SUB;
            6'b100100:            funct_alu = ALU_AND;
            6'b100101:            funct_alu = ALU_OR;
            6'b101010:            funct_alu = ALU_SLT;
            default:              funct_alu = ALU_ADD;
        endcase
    endfunction

    assign mem_rdy = (MEM_HS != 0) ? mem_ready : 1'b1;

    // DECODE is the only state that looks at the live IR fields. Later
    // states use op_q/fn_q, which are captured on the DECODE edge.
    assign illegal_dec = !op_legal(ct_inst) ||
                         ((ct_inst == OP_R) && !funct_legal(aluct_inst));

    assign ct_state   = state;
    assign ct_retired = retired;

    // ------------------------------------------------------------------
    // State, latched instruction fields and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
            retired <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_rdy) state <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= ct_inst;
                    fn_q <= aluct_inst;
                    if (ct_inst == OP_J) begin
                        state   <= S_FETCH;
                        retired <= retired + CNT_W'(1);
                    end else if (illegal_dec) begin
                        // Dropped without retiring.
                        state <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R, OP_ADDIU: state <= S_WB;
                        OP_LW, OP_SW:   state <= S_MEM;
                        OP_BEQ, OP_BNE: begin
                            state   <= S_FETCH;
                            retired <= retired + CNT_W'(1);
                        end
                        default:        state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_rdy) begin
                        if (op_q == OP_LW) begin
                            state <= S_WB;
                        end else begin
                            // Store completes once memory accepts it.
                            state   <= S_FETCH;
                            retired <= retired + CNT_W'(1);
                        end
                    end
                end
                S_WB: begin
                    state   <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath controls. Outputs are decoded from the current state
    // because the FETCH/MEM strobes and the branch PC write react to
    // mem_ready and alu_zero within the same cycle. Gating everything
    // with rst makes every strobe drop as soon as reset is asserted,
    // and lets the first fetch request appear as soon as reset is released.
    // ------------------------------------------------------------------
    always_comb begin
        ct_pc_wen    = 1'b0;
        ct_pc_src    = 2'b00;
        ct_ir_wen    = 1'b0;
        ct_rf_dst    = 1'b0;
        ct_rf_wen    = 1'b0;
        ct_alu_src_a = 1'b0;
        ct_alu_src_b = 2'b00;
        ct_alu       = ALU_AND;
        ct_mem_req   = 1'b0;
        ct_mem_ren   = 1'b0;
        ct_mem_wen   = 1'b0;
        ct_data_rf   = 1'b0;
        ct_illegal   = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    ct_mem_req   = 1'b1;
                    ct_mem_ren   = 1'b1;
                    ct_alu_src_a = 1'b0;
                    ct_alu_src_b = 2'b01;
                    ct_alu       = ALU_ADD;
                    ct_pc_src    = 2'b00;
                    ct_ir_wen    = mem_rdy;
                    ct_pc_wen    = mem_rdy;
                end
                S_DECODE: begin
                    // PC + (imm<<2) into ALUOut: the branch target.
                    ct_alu_src_a = 1'b0;
                    ct_alu_src_b = 2'b11;
                    ct_alu       = ALU_ADD;
                    if (ct_inst == OP_J) begin
                        ct_pc_wen = 1'b1;
                        ct_pc_src = 2'b10;
                    end else if (illegal_dec) begin
                        ct_illegal = 1'b1;
                    end
                end
                S_EXEC: begin
                    ct_alu_src_a = 1'b1;
                    case (op_q)
                        OP_R: begin
                            ct_alu_src_b = 2'b00;
                            ct_alu       = funct_alu(fn_q);
                        end
                        OP_ADDIU, OP_LW, OP_SW: begin
                            ct_alu_src_b = 2'b10;
                            ct_alu       = ALU_ADD;
                        end
                        OP_BEQ: begin
                            ct_alu_src_b = 2'b00;
                            ct_alu       = ALU_SUB;
                            ct_pc_src    = 2'b01;
                            ct_pc_wen    = alu_zero;
                        end
                        OP_BNE: begin
                            ct_alu_src_b = 2'b00;
                            ct_alu       = ALU_SUB;
                            ct_pc_src    = 2'b01;
                            ct_pc_wen    = !alu_zero;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    ct_mem_req = 1'b1;
                    ct_mem_ren = (op_q == OP_LW);
                    ct_mem_wen = (op_q == OP_SW);
                end
                S_WB: begin
                    ct_rf_wen  = 1'b1;
                    ct_rf_dst  = (op_q == OP_R);
                    ct_data_rf = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Drives instruction sequences into multicycle_control. For every driven
// cycle the reference model pushes the expected control word, and a mask of
// the fields that are defined in that state, into a queue. A negedge monitor
// pops one entry per cycle and compares it with the DUT outputs.
// The model expands each instruction into its phase list (fetch with
// stalls, decode, exec, memory with stalls, write-back) straight from the
// instruction-class rules. Directed sequences are followed by a randomized
// run. CNT_W=4 so that counter wrap occurs often.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int CNT_W = 4;
  localparam int ALU_W = 4;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_SLT = 4'b0111;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       ct_inst = 6'd0;
  logic [5:0]       aluct_inst = 6'd0;
  logic             alu_zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             ct_pc_wen;
  logic [1:0]       ct_pc_src;
  logic             ct_ir_wen;
  logic             ct_rf_dst;
  logic             ct_rf_wen;
  logic             ct_alu_src_a;
  logic [1:0]       ct_alu_src_b;
  logic [ALU_W-1:0] ct_alu;
  logic             ct_mem_req;
  logic             ct_mem_ren;
  logic             ct_mem_wen;
  logic             ct_data_rf;
  logic             ct_illegal;
  logic [2:0]       ct_state;
  logic [CNT_W-1:0] ct_retired;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W), .MEM_HS(1), .ALU_W(ALU_W)) dut (
    .clk(clk), .rst(rst), .ct_inst(ct_inst), .aluct_inst(aluct_inst),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .ct_pc_wen(ct_pc_wen), .ct_pc_src(ct_pc_src), .ct_ir_wen(ct_ir_wen),
    .ct_rf_dst(ct_rf_dst), .ct_rf_wen(ct_rf_wen), .ct_alu_src_a(ct_alu_src_a),
    .ct_alu_src_b(ct_alu_src_b), .ct_alu(ct_alu), .ct_mem_req(ct_mem_req),
    .ct_mem_ren(ct_mem_ren), .ct_mem_wen(ct_mem_wen), .ct_data_rf(ct_data_rf),
    .ct_illegal(ct_illegal), .ct_state(ct_state), .ct_retired(ct_retired)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [2:0] state;
    logic       pc_wen;
    logic [1:0] pc_src;
    logic       ir_wen;
    logic       rf_dst;
    logic       rf_wen;
    logic       src_a;
    logic [1:0] src_b;
    logic [3:0] alu;
    logic       mem_req;
    logic       mem_ren;
    logic       mem_wen;
    logic       data_rf;
    logic       illegal;
    logic [3:0] retired;
  } sig_t;

  localparam int W = $bits(sig_t);

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int ret_model = 0;
  int cyc = 0;

  // ---------------- reference model helpers ----------------
  function automatic bit op_ok(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDIU};
  endfunction

  function automatic bit fn_ok(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                      6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [3:0] fn_alu(input logic [5:0] fn);
    case (fn)
      6'b100010, 6'b100011: return A_SUB;
      6'b100100:            return A_AND;
      6'b100101:            return A_OR;
      6'b101010:            return A_SLT;
      default:              return A_ADD;
    endcase
  endfunction

  function automatic sig_t base(input logic [2:0] st);
    sig_t s;
    s = '0;
    s.state = st;
    s.retired = 4'(ret_model % 16);
    return s;
  endfunction

  // State, every strobe and the counter are always defined.
  function automatic sig_t strobe_mask();
    sig_t m;
    m = '0;
    m.state = '1;
    m.pc_wen = 1'b1;
    m.ir_wen = 1'b1;
    m.rf_wen = 1'b1;
    m.mem_req = 1'b1;
    m.mem_ren = 1'b1;
    m.mem_wen = 1'b1;
    m.illegal = 1'b1;
    m.retired = '1;
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic rst_v, input logic mr, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input sig_t e, input sig_t m);
    @(posedge clk);
    #1;
    rst = rst_v;
    mem_ready = mr;
    ct_inst = op;
    aluct_inst = fn;
    alu_zero = z;
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset(input int n);
    ret_model = 0;
    for (int i = 0; i < n; i++)
      step(1'b0, rbit(), 6'($urandom), 6'($urandom), rbit(), base(3'd0), strobe_mask());
  endtask

  function automatic sig_t fetch_exp(input bit done);
    sig_t e;
    e = base(3'd0);
    e.mem_req = 1'b1;
    e.mem_ren = 1'b1;
    e.src_b = 2'b01;
    e.alu = A_ADD;
    e.ir_wen = done;
    e.pc_wen = done;
    return e;
  endfunction

  function automatic sig_t fetch_mask();
    sig_t m;
    m = strobe_mask();
    m.src_a = 1'b1;
    m.src_b = '1;
    m.alu = '1;
    m.pc_src = '1;
    return m;
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fs, input int ms, input bit abort_in_mem);
    sig_t e, m;
    bit is_r, illegal, is_br;
    is_r = (op == OP_R);
    is_br = (op == OP_BEQ) || (op == OP_BNE);
    illegal = !op_ok(op) || (is_r && !fn_ok(fn));
    // fetch: fs stall cycles, then the accepting cycle
    for (int i = 0; i <= fs; i++)
      step(1'b1, (i == fs), op, fn, z, fetch_exp(i == fs), fetch_mask());
    // decode
    e = base(3'd1);
    m = strobe_mask();
    e.src_b = 2'b11;
    e.alu = A_ADD;
    m.src_a = 1'b1;
    m.src_b = '1;
    m.alu = '1;
    if (op == OP_J) begin
      e.pc_wen = 1'b1;
      e.pc_src = 2'b10;
      m.pc_src = '1;
    end
    if (illegal) e.illegal = 1'b1;
    step(1'b1, rbit(), op, fn, z, e, m);
    if (op == OP_J) begin
      ret_model++;
      return;
    end
    if (illegal) return;
    // exec
    e = base(3'd2);
    m = strobe_mask();
    e.src_a = 1'b1;
    m.src_a = 1'b1;
    m.src_b = '1;
    m.alu = '1;
    if (is_r) begin
      e.src_b = 2'b00;
      e.alu = fn_alu(fn);
    end else if (is_br) begin
      e.src_b = 2'b00;
      e.alu = A_SUB;
      e.pc_src = 2'b01;
      m.pc_src = '1;
      e.pc_wen = (op == OP_BEQ) ? z : !z;
    end else begin
      e.src_b = 2'b10;
      e.alu = A_ADD;
    end
    step(1'b1, rbit(), op, fn, z, e, m);
    if (is_br) begin
      ret_model++;
      return;
    end
    // memory: ms stall cycles, then completion
    if (op == OP_LW || op == OP_SW) begin
      for (int i = 0; i <= ms; i++) begin
        e = base(3'd3);
        e.mem_req = 1'b1;
        e.mem_ren = (op == OP_LW);
        e.mem_wen = (op == OP_SW);
        step(1'b1, (i == ms), op, fn, z, e, strobe_mask());
        if (abort_in_mem) return;
      end
      if (op == OP_SW) begin
        ret_model++;
        return;
      end
    end
    // write-back
    e = base(3'd4);
    m = strobe_mask();
    e.rf_wen = 1'b1;
    e.rf_dst = is_r;
    e.data_rf = (op == OP_LW);
    m.rf_dst = 1'b1;
    m.data_rf = 1'b1;
    step(1'b1, rbit(), op, fn, z, e, m);
    ret_model++;
  endtask

  // One stalled fetch cycle, then a named check of the retired count.
  task automatic retired_check(input int exp_ret, input string name);
    step(1'b1, 1'b0, 6'd0, 6'd0, 1'b0, fetch_exp(1'b0), fetch_mask());
    @(negedge clk);
    n_checks++;
    if (ct_retired !== 4'(exp_ret))
      $display("FAIL %s: ct_retired=%0d expected %0d", name, ct_retired, exp_ret);
    else
      n_pass++;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    sig_t a, e, m;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      a.state = ct_state;
      a.pc_wen = ct_pc_wen;
      a.pc_src = ct_pc_src;
      a.ir_wen = ct_ir_wen;
      a.rf_dst = ct_rf_dst;
      a.rf_wen = ct_rf_wen;
      a.src_a = ct_alu_src_a;
      a.src_b = ct_alu_src_b;
      a.alu = ct_alu;
      a.mem_req = ct_mem_req;
      a.mem_ren = ct_mem_ren;
      a.mem_wen = ct_mem_wen;
      a.data_rf = ct_data_rf;
      a.illegal = ct_illegal;
      a.retired = ct_retired;
      n_checks++;
      if (((a ^ e) & m) !== '0)
        $display("FAIL ctrl_word cyc=%0d state=%0d: got %h expected %h (mask %h)",
                 cyc, e.state, a, e, m);
      else
        n_pass++;
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] ops[7];
  logic [5:0] fns[7];

  initial begin
    logic [5:0] op, fn;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDIU};
    fns = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b101010};

    do_reset(3);

    // addu, lw, sw, beq taken, j with memory always ready
    run_instr(OP_R,   6'b100001, 1'b0, 0, 0, 1'b0);
    run_instr(OP_LW,  6'd0,      1'b0, 0, 0, 1'b0);
    run_instr(OP_SW,  6'd0,      1'b0, 0, 0, 1'b0);
    run_instr(OP_BEQ, 6'd0,      1'b1, 0, 0, 1'b0);
    run_instr(OP_J,   6'd0,      1'b0, 0, 0, 1'b0);
    retired_check(5, "seq_retired");

    // 17 jumps wrap a 4-bit counter to 1
    do_reset(2);
    for (int i = 0; i < 17; i++) run_instr(OP_J, 6'd0, 1'b0, 0, 0, 1'b0);
    retired_check(1, "wrap_retired");

    // illegal opcode and illegal funct do not retire
    run_instr(6'b111111, 6'd0,      1'b0, 0, 0, 1'b0);
    run_instr(OP_R,      6'b000111, 1'b0, 0, 0, 1'b0);
    retired_check(1, "illegal_no_retire");

    // bne not taken / taken, lw with 3 memory wait cycles, stalled fetch
    run_instr(OP_BNE, 6'd0, 1'b1, 0, 0, 1'b0);
    run_instr(OP_BNE, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_LW,  6'd0, 1'b0, 2, 3, 1'b0);
    run_instr(OP_ADDIU, 6'd0, 1'b0, 1, 0, 1'b0);
    retired_check(5, "directed_retired");

    // reset while sw waits in MEM, then a clean restart
    run_instr(OP_SW, 6'd0, 1'b0, 0, 2, 1'b1);
    do_reset(2);
    run_instr(OP_R, 6'b101010, 1'b0, 0, 0, 1'b0);
    retired_check(1, "after_reset_retired");

    // randomized run
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 8) < 7) ? ops[$urandom_range(0, 6)] : 6'($urandom);
      fn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 6)] : 6'($urandom);
      run_instr(op, fn, rbit(), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have parameter MEM_HS, default 1: 1 = honour mem_ready; 0 = mem_ready internally tied to 1.
REQ-003 SHALL have parameter ALU_W, default 4: width of ct_alu.
REQ-004 SHALL be clocked by one clock; reset is asynchronous and active-low.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- ct_inst  in  6  IR[31:26] opcode.
- aluct_inst  in  6  IR[5:0] funct.
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- ct_pc_wen  out  1  PC write.
- ct_pc_src  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- ct_ir_wen  out  1  IR write.
- ct_rf_dst  out  1  1 = rd, 0 = rt.
- ct_rf_wen  out  1  register-file write.
- ct_alu_src_a  out  1  0 = PC, 1 = rs.
- ct_alu_src_b  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- ct_alu  out  ALU_W  ALU operation.
- ct_mem_req  out  1  memory request.
- ct_mem_ren  out  1  memory read.
- ct_mem_wen  out  1  memory write.
- ct_data_rf  out  1  1 = memory data to RF, 0 = ALUOut.
- ct_illegal  out  1  one-cycle illegal-instruction pulse.
- ct_state  out  3  current state.
- ct_retired  out  CNT_W  retired-instruction count.

Function
REQ-006 SHALL decode opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addiu 001001; any other opcode is illegal.
REQ-007 SHALL encode ct_alu as: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111.
REQ-008 SHALL map R-type funct as: 100000/100001 -> ADD, 100010/100011 -> SUB, 100100 -> AND, 100101 -> OR, 101010 -> SLT; any other funct -> ADD with ct_illegal pulsed in DECODE.
REQ-009 SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, and drive ct_state with the current state.
REQ-010 SHALL drive in FETCH: ct_mem_req=1, ct_mem_ren=1, src_a=0, src_b=01, ct_alu=ADD, ct_pc_src=00.
REQ-011 SHALL assert ct_ir_wen and ct_pc_wen in FETCH only in a cycle where mem_ready=1, then go to DECODE; otherwise hold in FETCH with both strobes 0.
REQ-012 SHALL drive in DECODE: src_a=0, src_b=11, ct_alu=ADD, so ALUOut holds the branch target.
REQ-013 SHALL, in DECODE, latch the opcode and funct into internal registers; later states use only the latched values.
REQ-014 SHALL transition from DECODE as follows:
- j: ct_pc_wen=1, ct_pc_src=10, go to FETCH.
- illegal: ct_illegal=1, go to FETCH, no retire.
- all others: go to EXEC.
REQ-015 SHALL drive in EXEC: src_a=1.
- R: src_b=00, ct_alu per funct, go to WB.
- addiu, lw, sw: src_b=10, ct_alu=ADD; addiu goes to WB, lw/sw go to MEM.
REQ-016 SHALL, in EXEC for beq/bne, drive src_b=00, ct_alu=SUB, ct_pc_src=01, and ct_pc_wen = alu_zero (beq) or !alu_zero (bne), then go to FETCH.
REQ-017 SHALL drive in MEM: ct_mem_req=1, with ct_mem_ren=1 for lw or ct_mem_wen=1 for sw, held until mem_ready.
- lw goes to WB on mem_ready.
- sw goes to FETCH on mem_ready.
REQ-018 SHALL, in WB, pulse ct_rf_wen=1 for exactly one cycle, then go to FETCH.
- ct_rf_dst=1 for R, 0 otherwise.
- ct_data_rf=1 for lw only.
REQ-019 SHALL drive every strobe not specified for a state to 0 in that state.
REQ-020 SHALL increment ct_retired by 1 on each completion: WB->FETCH, sw MEM->FETCH, branch EXEC->FETCH, or j DECODE->FETCH; the counter wraps modulo 2^CNT_W.
REQ-021 SHALL give these latencies with mem_ready=1: j 2 cycles, beq/bne 3, R/addiu/sw 4, lw 5.
REQ-022 SHALL add one cycle to FETCH or MEM for every cycle mem_ready=0 when MEM_HS=1.

Reset
REQ-023 SHALL, while rst=0 (asynchronous), force the state to FETCH, ct_retired to 0, latched opcode/funct to 0, and every strobe output to 0, including ct_mem_req.
REQ-024 SHALL, when rst rises, start a fetch in the first cycle; a reset mid-instruction discards that instruction with no retire and no RF/memory write.

Verification
REQ-025 Sequence addu, lw, sw, beq (taken), j with mem_ready=1 -> ct_state traces 0124 01234 0123 012 01; ct_retired=5.
REQ-026 bne with alu_zero=1 -> ct_pc_wen stays 0 in EXEC; with alu_zero=0 -> ct_pc_wen=1 and ct_pc_src=01.
REQ-027 lw with mem_ready low for 3 cycles in MEM -> ct_mem_ren held for 4 cycles; WB follows; ct_rf_wen high for exactly 1 cycle with ct_data_rf=1.
REQ-028 Opcode 111111, then R funct 000111 -> ct_illegal pulses once for each in DECODE; ct_retired unchanged.
REQ-029 rst driven low in MEM of sw -> all strobes 0 immediately; after release ct_state=0 and ct_mem_req=1.
REQ-030 CNT_W=4 with 17 j instructions -> ct_retired=1.
